// File: rtl/qdec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qdec_pkg
// Purpose  : Shared constants and the phase-sequence lookup for the
//            quadrature decoder.
// Revision : 1.0 - initial release
// ============================================================================
package qdec_pkg;

  // Two-bit phase codes, written as {a, b}
  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_10 = 2'b10;

  // Direction encoding shared with the downstream up/down counter
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Code that legally follows 'state' when moving in direction 'dir'.
  // Up walks 00->01->11->10->00; down walks the same ring backwards.
  function automatic logic [1:0] qdec_next(input logic [1:0] state, input logic dir);
    logic [1:0] nxt;
    nxt = ST_00;
    case (state)
      ST_00:   nxt = (dir == DIR_UP) ? ST_01 : ST_10;
      ST_01:   nxt = (dir == DIR_UP) ? ST_11 : ST_00;
      ST_11:   nxt = (dir == DIR_UP) ? ST_10 : ST_01;
      ST_10:   nxt = (dir == DIR_UP) ? ST_00 : ST_11;
      default: nxt = ST_00;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qdec_sync.sv
`default_nettype none
// ============================================================================
// Module   : qdec_sync
// Purpose  : Single-bit multi-flop synchronizer for one quadrature phase,
//            with an optional stability filter behind it.
//            Filter present only when QDEC_FILTER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module qdec_sync #(
  parameter int SYNC_STAGES = 2
`ifdef QDEC_FILTER_EN
  , parameter int FILTER_CYCLES = 3
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic q_out
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the asynchronous pin through the synchronizer chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_in};
    end
  end

`ifdef QDEC_FILTER_EN
  localparam int c_CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(FILTER_CYCLES - 1);

  logic               r_filt;
  logic [c_CNT_W-1:0] r_cnt;

  // Accept a new level only once it has been seen on FILTER_CYCLES
  // consecutive samples; any return to the old level restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (r_sync[SYNC_STAGES-1] == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == c_LAST) begin
      r_filt <= r_sync[SYNC_STAGES-1];
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign q_out = r_filt;
`else
  assign q_out = r_sync[SYNC_STAGES-1];
`endif

endmodule
`default_nettype wire

// File: rtl/quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quadrature_decoder
// Purpose  : Decodes a quadrature pair into a step strobe, a direction flag
//            and a wrapping position count, with a sticky illegal-edge flag.
//            Optional glitch filter enabled by defining QDEC_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module quadrature_decoder #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clear,
  output logic             step,
  output logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             error
);

  import qdec_pkg::*;

`ifdef QDEC_FILTER_EN
  localparam bit c_FILTER_EN = 1'b1;
`else
  localparam bit c_FILTER_EN = 1'b0;
`endif

  // Cycles after reset release before the decoder input reflects the pins.
  // Priming waits for this so the pin level at release is taken as the
  // starting phase instead of looking like an edge away from 00.
  localparam int c_WARM   = SYNC_STAGES + (c_FILTER_EN ? FILTER_CYCLES : 0);
  localparam int c_WARM_W = $clog2(c_WARM + 1);

  logic                r_primed;
  logic [c_WARM_W-1:0] r_warm;
  logic [1:0]          r_prev;
  logic                r_step;
  logic                r_dir;
  logic [WIDTH-1:0]    r_count;
  logic                r_error;

  logic       w_a;
  logic       w_b;
  logic [1:0] w_cur;
  logic       w_up;
  logic       w_dn;
  logic       w_illegal;

  qdec_sync #(
    .SYNC_STAGES   (SYNC_STAGES)
`ifdef QDEC_FILTER_EN
    , .FILTER_CYCLES (FILTER_CYCLES)
`endif
  ) u_sync_a (
    .clk   (clk),
    .reset (reset),
    .d_in  (a_in),
    .q_out (w_a)
  );

  qdec_sync #(
    .SYNC_STAGES   (SYNC_STAGES)
`ifdef QDEC_FILTER_EN
    , .FILTER_CYCLES (FILTER_CYCLES)
`endif
  ) u_sync_b (
    .clk   (clk),
    .reset (reset),
    .d_in  (b_in),
    .q_out (w_b)
  );

  // Classify the synchronized code against the last accepted phase
  always_comb begin
    w_cur     = {w_a, w_b};
    w_up      = r_primed && (w_cur == qdec_next(r_prev, DIR_UP));
    w_dn      = r_primed && (w_cur == qdec_next(r_prev, DIR_DOWN));
    w_illegal = r_primed && (w_cur == ~r_prev);
  end

  // Priming, phase tracking, step strobe and direction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_primed <= 1'b0;
      r_warm   <= '0;
      r_prev   <= ST_00;
      r_step   <= 1'b0;
      r_dir    <= DIR_UP;
    end else begin
      r_step <= 1'b0;
      if (!r_primed) begin
        if (r_warm == c_WARM_W'(c_WARM)) begin
          r_prev   <= w_cur;
          r_primed <= 1'b1;
        end else begin
          r_warm <= r_warm + 1'b1;
        end
      end else begin
        // Always follow the pins, so an illegal jump resynchronizes too
        r_prev <= w_cur;
        if (w_up || w_dn) begin
          r_step <= 1'b1;
          r_dir  <= w_up ? DIR_UP : DIR_DOWN;
        end
      end
    end
  end

  // Position count and sticky error; clear overrides any same-cycle update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_error <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_up) begin
        r_count <= r_count + 1'b1;
      end else if (w_dn) begin
        r_count <= r_count - 1'b1;
      end
      if (w_illegal) begin
        r_error <= 1'b1;
      end
    end
  end

  assign step    = r_step;
  assign up_down = r_dir;
  assign count   = r_count;
  assign error   = r_error;

endmodule
`default_nettype wire

// File: tb/tb_quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quadrature_decoder
// Purpose  : Self-checking bench for quadrature_decoder: directed vector
//            table, hand-timed corner sequences and a randomized run checked
//            against a phase-arithmetic reference model.
//            QDEC_FILTER_EN selects the glitch-filter scenario instead.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quadrature_decoder;

  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
  localparam int FILT  = 3;
  localparam int MODV  = 1 << WIDTH;
  localparam int HOLD  = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             a_in;
  logic             b_in;
  logic             clear;
  logic             step;
  logic             up_down;
  logic [WIDTH-1:0] count;
  logic             error;

  int errors = 0;
  int checks = 0;

  quadrature_decoder #(
    .WIDTH         (WIDTH),
    .SYNC_STAGES   (SYNC),
    .FILTER_CYCLES (FILT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .a_in    (a_in),
    .b_in    (b_in),
    .clear   (clear),
    .step    (step),
    .up_down (up_down),
    .count   (count),
    .error   (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases are numbered around the ring; the signed distance between the
  // old and new phase (mod 4) tells up (+1), down (-1), illegal (2) or none.
  function automatic int phase_of(input logic [1:0] c);
    case (c)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] code_of(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  logic [1:0] m_seen [SYNC];   // pin codes sampled over the last SYNC edges
  logic [1:0] m_prev;
  bit         m_primed;
  int         m_edges;
  bit         m_step;
  bit         m_dir;
  int         m_cnt;
  bit         m_err;
  bit         en_model = 1'b0;

  task automatic model_edge();
    logic [1:0] cur;
    int d;
    m_step = 1'b0;
    if (reset) begin
      for (int i = 0; i < SYNC; i++) m_seen[i] = 2'b00;
      m_prev = 2'b00; m_primed = 1'b0; m_edges = 0;
      m_dir = 1'b1; m_cnt = 0; m_err = 1'b0;
    end else begin
      cur = m_seen[SYNC-1];
      if (!m_primed) begin
        // The pin level sampled at the first edge after release is now visible
        if (m_edges == SYNC) begin
          m_prev = cur;
          m_primed = 1'b1;
        end
        m_edges++;
      end else begin
        d = (phase_of(cur) - phase_of(m_prev) + 4) % 4;
        if (d == 1) begin m_step = 1'b1; m_dir = 1'b1; end
        if (d == 3) begin m_step = 1'b1; m_dir = 1'b0; end
        m_prev = cur;
        if (!clear) begin
          if (d == 1) m_cnt = (m_cnt + 1) % MODV;
          if (d == 3) m_cnt = (m_cnt + MODV - 1) % MODV;
          if (d == 2) m_err = 1'b1;
        end
      end
      if (clear) begin m_cnt = 0; m_err = 1'b0; end
      for (int i = SYNC - 1; i > 0; i--) m_seen[i] = m_seen[i-1];
      m_seen[0] = {a_in, b_in};
    end
  endtask

  // One clock: advance the model at the edge, sample the DUT just after it
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (en_model) begin
      check("rnd_step", step, m_step);
      check("rnd_dir", up_down, m_dir);
      check("rnd_count", count, m_cnt);
      check("rnd_error", error, m_err);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0] code;
    logic       clr;
    int         steps;
    int         cnt;
    logic       dir;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] c, input logic clr, input int s, input int n,
                     input logic d, input logic e);
    vec_t v;
    v.code = c; v.clr = clr; v.steps = s; v.cnt = n; v.dir = d; v.err = e;
    vecs.push_back(v);
  endtask

  initial begin
    int nsteps;
    int nerr;
    int r;
    int ph;
    logic [1:0] cp;

    reset = 1'b1; a_in = 1'b0; b_in = 1'b0; clear = 1'b0;
    repeat (3) tick();
    check("rst_step", step, 0);
    check("rst_dir", up_down, 1);
    check("rst_count", count, 0);
    check("rst_error", error, 0);
    @(negedge clk) reset = 1'b0;
    repeat (6) tick();

`ifdef QDEC_FILTER_EN
    // 2-clock glitch on a_in: shorter than the filter window
    @(negedge clk) a_in = 1'b1;
    tick();
    @(negedge clk) a_in = 1'b0;
    tick();
    nsteps = 0;
    repeat (15) begin tick(); nsteps += int'(step); end
    check("glitch_steps", nsteps, 0);
    check("glitch_error", error, 0);
    check("glitch_count", count, 0);
    // Stable edge 00->10 (down)
    @(negedge clk) a_in = 1'b1;
    nsteps = 0;
    repeat (15) begin tick(); nsteps += int'(step); end
    check("filt_steps", nsteps, 1);
    check("filt_count", count, MODV - 1);
    check("filt_dir", up_down, 0);
    check("filt_error", error, 0);
`else
    // 8 full up cycles, wrapping 15->0
    for (int i = 0; i < 32; i++) add(code_of(i + 1), 1'b0, 1, (i + 1) % MODV, 1'b1, 1'b0);
    add(2'b10, 1'b0, 1, 15, 1'b0, 1'b0);   // down from 0 wraps to 15
    add(2'b11, 1'b0, 1, 14, 1'b0, 1'b0);
    add(2'b01, 1'b0, 1, 13, 1'b0, 1'b0);
    add(2'b10, 1'b0, 0, 13, 1'b0, 1'b1);   // 01->10 double-bit change
    add(2'b00, 1'b0, 1, 14, 1'b1, 1'b1);   // later legal edge still counts, error sticks
    add(2'b00, 1'b1, 0, 0,  1'b1, 1'b0);   // clear
    for (int i = 1; i <= 7; i++) add(code_of(i), 1'b0, 1, i, 1'b1, 1'b0);
    add(2'b01, 1'b0, 0, 7, 1'b1, 1'b1);    // 10->01 illegal, count held at 7

    foreach (vecs[k]) begin
      @(negedge clk);
      {a_in, b_in} = vecs[k].code;
      clear = vecs[k].clr;
      nsteps = 0;
      repeat (HOLD) begin tick(); nsteps += int'(step); end
      check($sformatf("vec%0d_steps", k), nsteps, vecs[k].steps);
      check($sformatf("vec%0d_count", k), count, vecs[k].cnt);
      check($sformatf("vec%0d_dir", k), up_down, vecs[k].dir);
      check($sformatf("vec%0d_error", k), error, vecs[k].err);
    end
    @(negedge clk) clear = 1'b0;

    // Clear in the same cycle as a legal up edge from count 7
    @(negedge clk) {a_in, b_in} = 2'b11;
    tick(); tick();
    @(negedge clk) clear = 1'b1;
    tick();
    check("clr_edge_step", step, 1);
    check("clr_edge_count", count, 0);
    check("clr_edge_error", error, 0);
    check("clr_edge_dir", up_down, 1);
    @(negedge clk) clear = 1'b0;
    tick();
    check("clr_edge_step_after", step, 0);

    // Exact latency of a down edge 11->01 from count 0
    @(negedge clk) {a_in, b_in} = 2'b01;
    for (int i = 1; i <= SYNC + 2; i++) begin
      tick();
      check($sformatf("lat_step_clk%0d", i), step, (i == SYNC + 1) ? 1 : 0);
    end
    check("lat_count", count, MODV - 1);
    check("lat_dir", up_down, 0);

    // Pins held at 11 through reset release
    @(negedge clk) begin reset = 1'b1; {a_in, b_in} = 2'b11; end
    tick(); tick();
    check("rst11_count", count, 0);
    @(negedge clk) reset = 1'b0;
    nsteps = 0; nerr = 0;
    repeat (8) begin tick(); nsteps += int'(step); nerr += int'(error); end
    check("rst11_steps", nsteps, 0);
    check("rst11_error", nerr, 0);
    @(negedge clk) {a_in, b_in} = 2'b10;
    nsteps = 0;
    repeat (HOLD) begin tick(); nsteps += int'(step); end
    check("rst11_edge_steps", nsteps, 1);
    check("rst11_edge_count", count, 1);
    check("rst11_edge_dir", up_down, 1);

    // Randomized run against the reference model
    @(negedge clk) reset = 1'b1;
    tick();
    en_model = 1'b1;
    @(negedge clk) reset = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      cp = {a_in, b_in};
      ph = phase_of(cp);
      r  = int'($urandom_range(0, 99));
      if (r < 35)      {a_in, b_in} = code_of(ph + 1);
      else if (r < 70) {a_in, b_in} = code_of(ph + 3);
      else if (r < 74) {a_in, b_in} = ~cp;
      clear = ($urandom_range(0, 49) == 0);
      reset = (cyc >= 1000 && cyc < 1002);
      tick();
    end
    en_model = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
